// File: rtl/regfile_pkg.sv
// Shared constants for the MIPS-lite register file: architectural register
// indices, index width and the default reset values of $gp and $sp.
package regfile_pkg;

    localparam int REG_IDX_W = 5;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_IDX_W-1:0] REG_GP   = 5'd28;
    localparam logic [REG_IDX_W-1:0] REG_SP   = 5'd29;
    localparam logic [REG_IDX_W-1:0] REG_RA   = 5'd31;

    localparam logic [31:0] SP_INIT_DEF = 32'h0000_3FFC;
    localparam logic [31:0] GP_INIT_DEF = 32'h0000_1800;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: $0 and out-of-range indices read as zero.
// With REGFILE_BYPASS_EN defined, same-cycle write data is forwarded.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic [REG_IDX_W-1:0] rd_addr,
    input  logic [DATA_W-1:0]    regs [NREGS],
    input  logic                 wr_en,
    input  logic [REG_IDX_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 link_en,
    input  logic [DATA_W-1:0]    link_data,
    output logic [DATA_W-1:0]    rd_data
);

    logic in_range;
    assign in_range = (int'(rd_addr) < NREGS) && (rd_addr != REG_ZERO);

    always_comb begin
        rd_data = '0;
        if (in_range) begin
            rd_data = regs[rd_addr];
`ifdef REGFILE_BYPASS_EN
            // Forwarding mirrors write priority: the link write owns $31.
            if (link_en && (rd_addr == REG_RA)) begin
                rd_data = link_data;
            end else if (wr_en && (wr_addr == rd_addr)) begin
                rd_data = wr_data;
            end
`endif
        end
    end

`ifndef REGFILE_BYPASS_EN
    logic unused_bypass;
    assign unused_bypass = ^{wr_en, wr_addr, wr_data, link_en, link_data};
`endif

endmodule

// File: rtl/reg_file32.sv
// MIPS-lite general-purpose register file: two combinational read ports,
// one write-back port plus a $31 link port. Optional macro: REGFILE_BYPASS_EN.
module reg_file32
    import regfile_pkg::*;
#(
    parameter int                 DATA_W  = 32,
    parameter int                 NREGS   = 32,
    parameter logic [DATA_W-1:0]  SP_INIT = SP_INIT_DEF,
    parameter logic [DATA_W-1:0]  GP_INIT = GP_INIT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] rs_addr,
    input  logic [REG_IDX_W-1:0] rt_addr,
    output logic [DATA_W-1:0]    rs_data,
    output logic [DATA_W-1:0]    rt_data,
    input  logic                 wr_en,
    input  logic [REG_IDX_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 link_en,
    input  logic [DATA_W-1:0]    link_data
);

    logic [DATA_W-1:0] regs [NREGS];

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign regs[gi] = '0;
            end else begin : g_flop
                localparam logic [REG_IDX_W-1:0] IDX = REG_IDX_W'(gi);
                localparam logic [DATA_W-1:0] RST_VAL =
                    (IDX == REG_SP) ? SP_INIT :
                    (IDX == REG_GP) ? GP_INIT : '0;

                logic              link_hit;
                logic              wr_hit;
                logic [DATA_W-1:0] q_reg;

                assign link_hit = link_en && (IDX == REG_RA);
                assign wr_hit   = wr_en && (wr_addr == IDX);

                // Link takes priority so a colliding write-back to $31 is lost.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        q_reg <= RST_VAL;
                    end else if (link_hit) begin
                        q_reg <= link_data;
                    end else if (wr_hit) begin
                        q_reg <= wr_data;
                    end
                end

                assign regs[gi] = q_reg;
            end
        end
    endgenerate

    regfile_read_port #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_rs_port (
        .rd_addr   (rs_addr),
        .regs      (regs),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .link_en   (link_en),
        .link_data (link_data),
        .rd_data   (rs_data)
    );

    regfile_read_port #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_rt_port (
        .rd_addr   (rt_addr),
        .regs      (regs),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .link_en   (link_en),
        .link_data (link_data),
        .rd_data   (rt_data)
    );

endmodule

// File: tb/tb_reg_file32.sv
// Directed self-checking bench for reg_file32 (either REGFILE_BYPASS_EN build).
module tb_reg_file32;

    logic        clk;
    logic        reset;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        link_en;
    logic [31:0] link_data;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [31:0] sum;
    logic [31:0] exp_pre;

    reg_file32 dut (
        .clk       (clk),
        .reset     (reset),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .link_en   (link_en),
        .link_data (link_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
            $display("ok   %-22s got %08h", tag, obs);
        end else begin
            $display("FAIL %-22s got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; holds the write across one rising edge.
    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        rs_addr   = 5'd29;
        rt_addr   = 5'd28;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        link_en   = 1'b0;
        link_data = '0;

        #1;
        check("reset_sp", rs_data, 32'h0000_3FFC);
        check("reset_gp", rt_data, 32'h0000_1800);

        @(negedge clk);
        reset = 1'b0;
        write_reg(5'd5, 32'hDEAD_BEEF);
        rs_addr = 5'd5;
        rt_addr = 5'd29;
        #1;
        check("wr_r5", rs_data, 32'hDEAD_BEEF);

        // Mid-cycle asynchronous reset, with a write held across an edge.
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_r5", rs_data, 32'h0000_0000);
        check("async_rst_sp", rt_data, 32'h0000_3FFC);
        rt_addr = 5'd28;
        #1;
        check("async_rst_gp", rt_data, 32'h0000_1800);
        wr_en   = 1'b1;
        wr_addr = 5'd6;
        wr_data = 32'h0000_0001;
        @(negedge clk);
        wr_en   = 1'b0;
        reset   = 1'b0;
        rs_addr = 5'd6;
        #1;
        check("wr_during_rst", rs_data, 32'h0000_0000);

        // Writes to $0 are discarded.
        @(negedge clk);
        rs_addr = 5'd0;
        wr_en   = 1'b1;
        wr_addr = 5'd0;
        wr_data = 32'hFFFF_FFFF;
        #1;
        check("r0_pre_edge", rs_data, 32'h0000_0000);
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        check("r0_post_edge", rs_data, 32'h0000_0000);

        // Operand pair feeding the adder.
        @(negedge clk);
        write_reg(5'd8, 32'h0000_0007);
        write_reg(5'd9, 32'hFFFF_FFF9);
        rs_addr = 5'd8;
        rt_addr = 5'd9;
        #1;
        check("rs_r8", rs_data, 32'h0000_0007);
        check("rt_r9", rt_data, 32'hFFFF_FFF9);
        sum = rs_data + rt_data;
        check("alu_sum", sum, 32'h0000_0000);
        check("alu_zout", {31'd0, sum == 32'd0}, 32'h0000_0001);

        // Link and write-back collide on $31: link wins.
        @(negedge clk);
        rs_addr   = 5'd31;
        link_en   = 1'b1;
        link_data = 32'h0040_0010;
        wr_en     = 1'b1;
        wr_addr   = 5'd31;
        wr_data   = 32'h1234_5678;
`ifdef REGFILE_BYPASS_EN
        exp_pre = 32'h0040_0010;
`else
        exp_pre = 32'h0000_0000;
`endif
        #1;
        check("r31_pre_edge", rs_data, exp_pre);
        @(negedge clk);
        link_en = 1'b0;
        wr_en   = 1'b0;
        #1;
        check("r31_link_wins", rs_data, 32'h0040_0010);

        // Same-cycle read of a register being written.
        @(negedge clk);
        rs_addr = 5'd10;
        wr_en   = 1'b1;
        wr_addr = 5'd10;
        wr_data = 32'hA5A5_A5A5;
`ifdef REGFILE_BYPASS_EN
        exp_pre = 32'hA5A5_A5A5;
`else
        exp_pre = 32'h0000_0000;
`endif
        #1;
        check("r10_same_cycle", rs_data, exp_pre);
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        check("r10_after_edge", rs_data, 32'hA5A5_A5A5);

        // Link and write-back to different registers on one edge.
        @(negedge clk);
        link_en   = 1'b1;
        link_data = 32'h0000_0100;
        wr_en     = 1'b1;
        wr_addr   = 5'd4;
        wr_data   = 32'h0000_0042;
        @(negedge clk);
        link_en = 1'b0;
        wr_en   = 1'b0;
        rs_addr = 5'd31;
        rt_addr = 5'd4;
        #1;
        check("dual_r31", rs_data, 32'h0000_0100);
        check("dual_r4", rt_data, 32'h0000_0042);

        rs_addr = 5'd4;
        #1;
        check("same_idx_rs", rs_data, 32'h0000_0042);
        check("same_idx_rt", rt_data, 32'h0000_0042);
        rs_addr = 5'd8;
        rt_addr = 5'd29;
        #1;
        check("r8_retained", rs_data, 32'h0000_0007);
        check("sp_retained", rt_data, 32'h0000_3FFC);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/reg_file32.md
Name: reg_file32

Overview:
- General-purpose register file for the MIPS-lite single-cycle datapath, directly upstream of the 32-bit ALU.
- Read port 1 (rs) drives ALU operand a; read port 2 (rt) drives the operand-b mux (rt data or sign-extended immediate).
- Accepts one write-back per cycle from the ALU/memory result mux, plus a dedicated link write of PC+4 into $31 for jal-type instructions.

Parameters:
- DATA_W, 32, register width in bits.
- NREGS, 32, number of architectural registers; index width is fixed at 5.
- SP_INIT, 32'h0000_3FFC, reset value of $29 (stack pointer).
- GP_INIT, 32'h0000_1800, reset value of $28 (global pointer).

Ports:
- clk  in  1  Single clock; all writes on rising edge.
- reset  in  1  Asynchronous, active-high reset.
- rs_addr  in  5  Read port 1 index.
- rt_addr  in  5  Read port 2 index.
- rs_data  out  32  Read port 1 data, to ALU operand a.
- rt_data  out  32  Read port 2 data, to operand-b mux and memory write data.
- wr_en  in  1  Write-back enable (RegWrite).
- wr_addr  in  5  Write-back index (rd or rt, already muxed).
- wr_data  in  32  Write-back data (ALU sum or memory read data).
- link_en  in  1  Link write enable; writes link_data into $31.
- link_data  in  32  PC+4 from the fetch logic.

Behaviour:
- Reset is asynchronous and active-high: all registers clear to 0 immediately, except $29 = SP_INIT and $28 = GP_INIT. Outputs follow combinationally, so rs_data and rt_data show the reset contents of the addressed registers while reset is high.
- While reset is high, writes are ignored.
- Reset deassertion mid-cycle:
  - The first write is taken on the first rising edge with reset low.
  - A write request present on a rising edge coincident with reset high is dropped.
- Reads are combinational, with zero latency: rs_data = R[rs_addr] and rt_data = R[rt_addr]. This is required for single-cycle operation.
- $0 is hardwired to zero:
  - Reads of index 0 return 0.
  - Writes to index 0 from either write source are discarded, with no side effects.
- Writes take effect on the rising clk edge and are visible on the read ports after that edge.
  - Without the bypass feature, a read of the same index in the same cycle returns the old value.
- Link write: when link_en=1, $31 <= link_data on the edge.
- Simultaneous events:
  - Both writes enabled with wr_addr = 31: link_data wins, and the wr_data write is discarded.
  - Both writes enabled with wr_addr != 31: both writes occur on the same edge.
  - rs_addr = rt_addr: both ports return identical data.
- Width rules: the 5-bit index wraps naturally. If NREGS < 32, out-of-range reads return 0 and out-of-range writes are discarded.
- No X propagation: every register has a defined value after reset.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through bypass. When a read index equals a write index that is enabled in the same cycle, that read port returns the incoming write data combinationally.
  - Bypass uses the same priority as the write itself: link over wr for index 31.
  - Index 0 is never bypassed and always reads 0.
- Undefined: no bypass logic is built. Same-cycle reads return the pre-edge value.

Decomposition:
- Shared package regfile_pkg holds:
  - Register index constants: REG_ZERO=0, REG_GP=28, REG_SP=29, REG_RA=31.
  - Index width REG_IDX_W=5.
  - Reset value constants SP_INIT_DEF and GP_INIT_DEF.
- One sub-module is natural: regfile_read_port. It implements the index-0 zeroing, the range check and the optional bypass mux, and is instantiated twice (rs and rt).
- Write and storage logic stays in the top module.

Test Plan:
- Assert reset high mid-cycle after writing $5 = 32'hDEAD_BEEF. Required: reads of $5 = 0, $29 = 32'h0000_3FFC and $28 = 32'h0000_1800 immediately, without waiting for a clock edge.
- wr_en=1, wr_addr=0, wr_data=32'hFFFF_FFFF, then read rs_addr=0. Required: 0 before and after the edge.
- Write $8 = 32'h0000_0007 and $9 = 32'hFFFF_FFF9 on successive edges. Then read rs=8, rt=9. Required: rs_data = 7, rt_data = 32'hFFFF_FFF9, and these drive the ALU to sum = 0 with zout = 1 on an add.
- In the same cycle, link_en=1 with link_data = 32'h0040_0010, and wr_en=1 with wr_addr=31 and wr_data=32'h1234_5678. Required: after the edge $31 = 32'h0040_0010.
- Same-cycle write $10 = 32'hA5A5_A5A5 while reading rs=10, with $10 previously 0. Required: rs_data = 32'hA5A5_A5A5 with REGFILE_BYPASS_EN defined; rs_data = 0 without it. Both builds read 32'hA5A5_A5A5 after the edge.
- Simultaneous link write ($31 = 32'h0000_0100) and wr write ($4 = 32'h0000_0042). Required: both registers update on the same edge.
